// File: rtl/ram_pkg.sv
// Shared types and default sizes for the parametrised Hack RAM.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_t;

  localparam int HACK_DATA_W = 16;
  localparam int HACK_ADDR_W = 12;

endpackage

// File: rtl/ram_param_sweep_if.sv
// CPU-side access bus of the RAM: request signals in, read data and status out.
interface ram_param_sweep_if
  import ram_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W
);

  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              clear;
  logic [DATA_W-1:0] data_out;
  logic              ready;
  logic              addr_err;

  modport master (
    output load, address, data_in, clear,
    input  data_out, ready, addr_err
  );

  modport slave (
    input  load, address, data_in, clear,
    output data_out, ready, addr_err
  );

endinterface

// File: rtl/ram_sweep_ctrl.sv
// Clear engine: walks a counter over every implemented word after reset or a
// clear request, and raises ready on the edge that zeroes the last word.
module ram_sweep_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  output logic              o_sweep,
  output logic [ADDR_W-1:0] o_sweep_addr,
  output logic              o_ready
);

  // One extra counter bit so DEPTH == 2**ADDR_W ends without wrapping.
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(DEPTH - 1);

  ram_state_t      r_state;
  logic [ADDR_W:0] r_cnt;
  logic            r_ready;

  // Sweep FSM: CLEAR counts through the array, IDLE waits for a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RAM_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RAM_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_state <= RAM_IDLE;
            r_ready <= 1'b1;
          end
        end
        RAM_IDLE: begin
          if (i_clear) begin
            r_state <= RAM_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= RAM_CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_sweep      = (r_state == RAM_CLEAR);
  assign o_sweep_addr = r_cnt[ADDR_W-1:0];
  assign o_ready      = r_ready;

endmodule

// File: rtl/ram_param_sweep.sv
// Single-port synchronous RAM, write-first registered read, with a built-in
// clear engine so the array itself carries no reset.
module ram_param_sweep
  import ram_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DEPTH  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_param_sweep_if.slave bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_addr_err;

  logic              w_sweep;
  logic              w_ready;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_in_range;
  logic              w_user_we;

  ram_sweep_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (bus.clear),
    .o_sweep      (w_sweep),
    .o_sweep_addr (w_sweep_addr),
    .o_ready      (w_ready)
  );

  // A fully populated address space needs no range check.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign w_in_range = 1'b1;
    end else begin : g_partial
      localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
      assign w_in_range = ({1'b0, bus.address} < LP_DEPTH);
    end
  endgenerate

  // A clear request wins over a write issued in the same cycle.
  assign w_user_we = w_ready & ~bus.clear & bus.load & w_in_range;

  // Array write port, shared by the sweep and the CPU; no reset on storage.
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_mem[w_sweep_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[bus.address] <= bus.data_in;
    end
  end

  // Registered read data and range flag; write-first forwards data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_addr_err <= 1'b0;
    end else if (w_sweep || bus.clear) begin
      r_data_out <= '0;
      r_addr_err <= 1'b0;
    end else if (!w_in_range) begin
      r_data_out <= '0;
      r_addr_err <= 1'b1;
    end else if (bus.load) begin
      r_data_out <= bus.data_in;
      r_addr_err <= 1'b0;
    end else begin
      r_data_out <= r_mem[bus.address];
      r_addr_err <= 1'b0;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.addr_err = r_addr_err;
  assign bus.ready    = w_ready;

endmodule

// File: tb/tb_ram_param_sweep.sv
// Drives a full-depth (4096) and a partial-depth (3000) RAM in lockstep and
// compares both against an array-based reference model.
module tb_ram_param_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ram_param_sweep_if #(.DATA_W(16), .ADDR_W(12)) bus_a ();
  ram_param_sweep_if #(.DATA_W(16), .ADDR_W(12)) bus_b ();

  ram_param_sweep #(.DATA_W(16), .ADDR_W(12), .DEPTH(4096)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ram_param_sweep #(.DATA_W(16), .ADDR_W(12), .DEPTH(3000)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents, remaining clear edges, expected outputs.
  logic [15:0] m_mem  [2][4096];
  int          m_depth[2] = '{4096, 3000};
  int          m_left [2];
  logic [15:0] m_dout [2];
  logic        m_err  [2];

  function automatic logic [15:0] obs_dout(input int k);
    return (k == 0) ? bus_a.data_out : bus_b.data_out;
  endfunction

  function automatic logic obs_ready(input int k);
    return (k == 0) ? bus_a.ready : bus_b.ready;
  endfunction

  function automatic logic obs_err(input int k);
    return (k == 0) ? bus_a.addr_err : bus_b.addr_err;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = m_depth[k];
      m_dout[k] = 16'h0000;
      m_err[k]  = 1'b0;
      for (int j = 0; j < 4096; j++) m_mem[k][j] = 16'h0000;
    end
  endtask

  task automatic model_edge(input logic ld, input logic [11:0] ad,
                            input logic [15:0] d, input logic cl);
    for (int k = 0; k < 2; k++) begin
      if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        m_dout[k] = 16'h0000;
        m_err[k]  = 1'b0;
      end else if (cl) begin
        m_left[k] = m_depth[k];
        for (int j = 0; j < 4096; j++) m_mem[k][j] = 16'h0000;
        m_dout[k] = 16'h0000;
        m_err[k]  = 1'b0;
      end else if (int'(ad) >= m_depth[k]) begin
        m_dout[k] = 16'h0000;
        m_err[k]  = 1'b1;
      end else if (ld) begin
        m_mem[k][ad] = d;
        m_dout[k]    = d;
        m_err[k]     = 1'b0;
      end else begin
        m_dout[k] = m_mem[k][ad];
        m_err[k]  = 1'b0;
      end
    end
  endtask

  // Drive one request on both buses at the falling edge, clock it, return at
  // the next falling edge with outputs settled.
  task automatic cycle(input logic ld, input logic [11:0] ad,
                       input logic [15:0] d, input logic cl);
    bus_a.load = ld; bus_a.address = ad; bus_a.data_in = d; bus_a.clear = cl;
    bus_b.load = ld; bus_b.address = ad; bus_b.data_in = d; bus_b.clear = cl;
    @(posedge clk);
    model_edge(ld, ad, d, cl);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] ad;
    bus_a.load = 0; bus_a.address = '0; bus_a.data_in = '0; bus_a.clear = 0;
    bus_b.load = 0; bus_b.address = '0; bus_b.data_in = '0; bus_b.clear = 0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks += 3;
      if (obs_dout(k) !== 16'h0000) begin n_errors++; $display("FAIL reset_dout dut%0d got %h want 0000", k, obs_dout(k)); end
      if (obs_ready(k) !== 1'b0) begin n_errors++; $display("FAIL reset_ready dut%0d got %b want 0", k, obs_ready(k)); end
      if (obs_err(k) !== 1'b0) begin n_errors++; $display("FAIL reset_err dut%0d got %b want 0", k, obs_err(k)); end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Inputs (including clear) must be ignored while sweeping.
    for (int i = 1; i <= 4096; i++) begin
      ad = 12'($urandom_range(0, 4095));
      cycle(1'($urandom_range(0, 1)), ad, 16'($urandom),
            (i < 2900) ? 1'($urandom_range(0, 1)) : 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_checks += 3;
        if (obs_ready(k) !== (m_left[k] == 0)) begin n_errors++; $display("FAIL sweep_ready dut%0d edge %0d got %b want %b", k, i, obs_ready(k), m_left[k] == 0); end
        if (obs_dout(k) !== m_dout[k]) begin n_errors++; $display("FAIL sweep_dout dut%0d edge %0d got %h want %h", k, i, obs_dout(k), m_dout[k]); end
        if (obs_err(k) !== m_err[k]) begin n_errors++; $display("FAIL sweep_err dut%0d edge %0d got %b want %b", k, i, obs_err(k), m_err[k]); end
      end
    end
    n_checks++;
    if (bus_a.ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_4096 dut0 got %b want 1", bus_a.ready); end
    cycle(1'b0, 12'd0, 16'h0, 1'b0);
    n_checks++;
    if (bus_a.data_out !== 16'h0000) begin n_errors++; $display("FAIL read0_after_reset dut0 got %h want 0000", bus_a.data_out); end
    cycle(1'b0, 12'd4095, 16'h0, 1'b0);
    n_checks++;
    if (bus_a.data_out !== 16'h0000) begin n_errors++; $display("FAIL read4095_after_reset dut0 got %h want 0000", bus_a.data_out); end
  endtask

  task automatic test_write_read();
    logic [11:0] addrs [3] = '{12'd0, 12'd2500, 12'd3000};
    logic [15:0] vals  [3] = '{16'h1234, 16'h5678, 16'habcd};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, addrs[i], vals[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_checks += 2;
        if (obs_dout(k) !== m_dout[k]) begin n_errors++; $display("FAIL write_first dut%0d addr %0d got %h want %h", k, addrs[i], obs_dout(k), m_dout[k]); end
        if (obs_err(k) !== m_err[k]) begin n_errors++; $display("FAIL write_err dut%0d addr %0d got %b want %b", k, addrs[i], obs_err(k), m_err[k]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, addrs[i], 16'h0, 1'b0);
      n_checks++;
      if (bus_a.data_out !== vals[i]) begin n_errors++; $display("FAIL readback dut0 addr %0d got %h want %h", addrs[i], bus_a.data_out, vals[i]); end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_dout(k) !== m_dout[k]) begin n_errors++; $display("FAIL readback_model dut%0d addr %0d got %h want %h", k, addrs[i], obs_dout(k), m_dout[k]); end
      end
    end
  endtask

  task automatic test_read_no_write();
    cycle(1'b1, 12'd450, 16'hdcba, 1'b0);
    cycle(1'b0, 12'd662, 16'hbbbb, 1'b0);
    n_checks++;
    if (bus_a.data_out !== 16'h0000) begin n_errors++; $display("FAIL read662 dut0 got %h want 0000", bus_a.data_out); end
    cycle(1'b0, 12'd662, 16'h0, 1'b0);
    n_checks++;
    if (bus_a.data_out !== 16'h0000) begin n_errors++; $display("FAIL reread662 dut0 got %h want 0000", bus_a.data_out); end
    cycle(1'b0, 12'd450, 16'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_dout(k) !== 16'hdcba) begin n_errors++; $display("FAIL read450 dut%0d got %h want dcba", k, obs_dout(k)); end
    end
  endtask

  task automatic test_clear();
    logic [11:0] addrs [3] = '{12'd0, 12'd450, 12'h707};
    cycle(1'b1, 12'h707, 16'hdef0, 1'b1);
    for (int i = 1; i <= 4096; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_ready(k) !== (m_left[k] == 0)) begin n_errors++; $display("FAIL clear_ready dut%0d edge %0d got %b want %b", k, i, obs_ready(k), m_left[k] == 0); end
      end
      cycle(1'b0, 12'd0, 16'h0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_ready(k) !== 1'b1) begin n_errors++; $display("FAIL clear_done dut%0d got %b want 1", k, obs_ready(k)); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, addrs[i], 16'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_dout(k) !== 16'h0000) begin n_errors++; $display("FAIL read_after_clear dut%0d addr %0d got %h want 0000", k, addrs[i], obs_dout(k)); end
      end
    end
  endtask

  task automatic test_out_of_range();
    cycle(1'b1, 12'd3500, 16'hffff, 1'b0);
    n_checks += 3;
    if (bus_b.addr_err !== 1'b1) begin n_errors++; $display("FAIL oor_err dut1 got %b want 1", bus_b.addr_err); end
    if (bus_b.data_out !== 16'h0000) begin n_errors++; $display("FAIL oor_dout dut1 got %h want 0000", bus_b.data_out); end
    if (bus_a.data_out !== 16'hffff) begin n_errors++; $display("FAIL inrange_write dut0 got %h want ffff", bus_a.data_out); end
    cycle(1'b0, 12'd500, 16'h0, 1'b0);
    n_checks += 2;
    if (bus_b.addr_err !== 1'b0) begin n_errors++; $display("FAIL oor_err_clear dut1 got %b want 0", bus_b.addr_err); end
    if (bus_b.data_out !== 16'h0000) begin n_errors++; $display("FAIL alias500 dut1 got %h want 0000", bus_b.data_out); end
    cycle(1'b0, 12'd3500, 16'h0, 1'b0);
    n_checks += 2;
    if (bus_a.data_out !== 16'hffff) begin n_errors++; $display("FAIL read3500 dut0 got %h want ffff", bus_a.data_out); end
    if (bus_b.addr_err !== 1'b1) begin n_errors++; $display("FAIL oor_read_err dut1 got %b want 1", bus_b.addr_err); end
  endtask

  task automatic test_random();
    logic [11:0] ad;
    for (int i = 0; i < 600; i++) begin
      // Bias addresses toward a small window so reads hit written words.
      ad = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(2990, 3010))
                                       : 12'($urandom_range(0, 4095));
      cycle(1'($urandom_range(0, 1)), ad, 16'($urandom), 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_checks += 2;
        if (obs_dout(k) !== m_dout[k]) begin n_errors++; $display("FAIL random_dout dut%0d addr %0d got %h want %h", k, ad, obs_dout(k), m_dout[k]); end
        if (obs_err(k) !== m_err[k]) begin n_errors++; $display("FAIL random_err dut%0d addr %0d got %b want %b", k, ad, obs_err(k), m_err[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int ready_edge [2];
    cycle(1'b1, 12'd5, 16'h0bad, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 12'd0, 16'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks += 2;
      if (obs_dout(k) !== 16'h0000) begin n_errors++; $display("FAIL midreset_dout dut%0d got %h want 0000", k, obs_dout(k)); end
      if (obs_ready(k) !== 1'b0) begin n_errors++; $display("FAIL midreset_ready dut%0d got %b want 0", k, obs_ready(k)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_edge = '{0, 0};
    for (int i = 1; i <= 4200; i++) begin
      cycle(1'b0, 12'd5, 16'h0, 1'b0);
      for (int k = 0; k < 2; k++)
        if (ready_edge[k] == 0 && obs_ready(k) === 1'b1) ready_edge[k] = i;
    end
    for (int k = 0; k < 2; k++) begin
      n_checks += 2;
      if (ready_edge[k] != m_depth[k]) begin n_errors++; $display("FAIL midreset_sweep_len dut%0d got %0d want %0d", k, ready_edge[k], m_depth[k]); end
      if (obs_dout(k) !== 16'h0000) begin n_errors++; $display("FAIL midreset_read5 dut%0d got %h want 0000", k, obs_dout(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_no_write();
    test_clear();
    test_out_of_range();
    test_random();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
